// File: rtl/alu8b_pkg.sv
// Shared opcode map for the 8-bit ALU: class nibbles and full opcode constants.
// The RTL core and the testbench both import this package.
package alu8b_pkg;

    localparam logic [3:0] CLASS_ARITH = 4'h6;
    localparam logic [3:0] CLASS_LOGIC = 4'h7;
    localparam logic [3:0] CLASS_SHIFT = 4'h8;
    localparam logic [3:0] CLASS_CMP   = 4'h9;

    localparam logic [7:0] OP_PASSA = 8'h60;
    localparam logic [7:0] OP_PASSB = 8'h61;
    localparam logic [7:0] OP_INC   = 8'h62;
    localparam logic [7:0] OP_ADD   = 8'h63;
    localparam logic [7:0] OP_SUB   = 8'h64;
    localparam logic [7:0] OP_RSUB  = 8'h65;
    localparam logic [7:0] OP_DEC   = 8'h66;
    localparam logic [7:0] OP_NEG   = 8'h67;

    localparam logic [7:0] OP_AND   = 8'h78;
    localparam logic [7:0] OP_OR    = 8'h79;
    localparam logic [7:0] OP_XOR   = 8'h7A;
    localparam logic [7:0] OP_NAND  = 8'h7B;
    localparam logic [7:0] OP_NOR   = 8'h7C;
    localparam logic [7:0] OP_XNOR  = 8'h7D;
    localparam logic [7:0] OP_NOTA  = 8'h7E;
    localparam logic [7:0] OP_NOTB  = 8'h7F;

    localparam logic [7:0] OP_SHL   = 8'h88;
    localparam logic [7:0] OP_SHR   = 8'h89;
    localparam logic [7:0] OP_ROL   = 8'h8A;
    localparam logic [7:0] OP_ROR   = 8'h8B;
    localparam logic [7:0] OP_ASR   = 8'h8C;
    localparam logic [7:0] OP_SHL1  = 8'h8D;
    localparam logic [7:0] OP_SHR1  = 8'h8E;
    localparam logic [7:0] OP_SWAP  = 8'h8F;

    localparam logic [7:0] OP_EQ    = 8'h90;
    localparam logic [7:0] OP_LTU   = 8'h91;
    localparam logic [7:0] OP_LTS   = 8'h92;
    localparam logic [7:0] OP_MINU  = 8'h93;
    localparam logic [7:0] OP_MAXU  = 8'h94;

endpackage

// File: rtl/alu8b_core.sv
// Purely combinational ALU datapath: decodes the full opcode and produces the result.
// Unlisted opcodes fall through to 0x00.
module alu8b_core
    import alu8b_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result
);

    logic [2:0] amt;
    logic [3:0] backAmt;
    logic [7:0] rotL;
    logic [7:0] rotR;

    // A right/left shift by 8 yields zero, so amount 0 rotates to A unchanged.
    assign amt     = b[2:0];
    assign backAmt = 4'd8 - {1'b0, amt};
    assign rotL    = (a << amt) | (a >> backAmt);
    assign rotR    = (a >> amt) | (a << backAmt);

    always_comb begin
        result = 8'h00;
        case (opcode)
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_INC:   result = a + 8'd1;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_RSUB:  result = b - a;
            OP_DEC:   result = a - 8'd1;
            OP_NEG:   result = 8'd0 - a;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NAND:  result = ~(a & b);
            OP_NOR:   result = ~(a | b);
            OP_XNOR:  result = ~(a ^ b);
            OP_NOTA:  result = ~a;
            OP_NOTB:  result = ~b;
            OP_SHL:   result = a << amt;
            OP_SHR:   result = a >> amt;
            OP_ROL:   result = rotL;
            OP_ROR:   result = rotR;
            OP_ASR:   result = $unsigned($signed(a) >>> amt);
            OP_SHL1:  result = {a[6:0], 1'b0};
            OP_SHR1:  result = {1'b0, a[7:1]};
            OP_SWAP:  result = {a[3:0], a[7:4]};
            OP_EQ:    result = {7'd0, a == b};
            OP_LTU:   result = {7'd0, a < b};
            OP_LTS:   result = {7'd0, $signed(a) < $signed(b)};
            OP_MINU:  result = (a < b) ? a : b;
            OP_MAXU:  result = (a > b) ? a : b;
            default:  result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_8b.sv
// Registered 8-bit ALU: combinational core result captured into z every clock.
// z clears asynchronously whenever rst_n is low.
module alu_8b
    import alu8b_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] z
);

    logic [7:0] z_d;
    logic [7:0] z_q;

    alu8b_core u_core (
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .result (z_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 8'h00;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_alu_8b.sv
// Self-checking bench for alu_8b: directed cases, full opcode sweep and random
// operations compared against an arithmetic reference model.
module tb_alu_8b;
    import alu8b_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;

    int checks;
    int errors;

    alu_8b dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from integer arithmetic and bit-by-bit loops.
    function automatic logic [7:0] refModel(input logic [7:0] op, input logic [7:0] av,
                                            input logic [7:0] bv);
        int ai, bi, r, amt, sa, sb;
        ai  = av;
        bi  = bv;
        amt = bi % 8;
        sa  = (ai >= 128) ? ai - 256 : ai;
        sb  = (bi >= 128) ? bi - 256 : bi;
        r   = 0;
        case (op)
            8'h60: r = ai;
            8'h61: r = bi;
            8'h62: r = (ai + 1) % 256;
            8'h63: r = (ai + bi) % 256;
            8'h64: r = (ai - bi + 256) % 256;
            8'h65: r = (bi - ai + 256) % 256;
            8'h66: r = (ai + 255) % 256;
            8'h67: r = (256 - ai) % 256;
            8'h78: r = ai & bi;
            8'h79: r = ai | bi;
            8'h7A: r = ai ^ bi;
            8'h7B: r = 255 - (ai & bi);
            8'h7C: r = 255 - (ai | bi);
            8'h7D: r = 255 - (ai ^ bi);
            8'h7E: r = 255 - ai;
            8'h7F: r = 255 - bi;
            8'h88: r = (ai * (1 << amt)) % 256;
            8'h89: r = ai / (1 << amt);
            8'h8A: begin
                r = ai;
                for (int i = 0; i < amt; i++) r = (r * 2) % 256 + r / 128;
            end
            8'h8B: begin
                r = ai;
                for (int i = 0; i < amt; i++) r = r / 2 + (r % 2) * 128;
            end
            8'h8C: begin
                r = ai;
                for (int i = 0; i < amt; i++) r = r / 2 + ((ai >= 128) ? 128 : 0);
            end
            8'h8D: r = (ai * 2) % 256;
            8'h8E: r = ai / 2;
            8'h8F: r = (ai % 16) * 16 + ai / 16;
            8'h90: r = (ai == bi) ? 1 : 0;
            8'h91: r = (ai < bi) ? 1 : 0;
            8'h92: r = (sa < sb) ? 1 : 0;
            8'h93: r = (ai < bi) ? ai : bi;
            8'h94: r = (ai > bi) ? ai : bi;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    // Drive inputs away from the active edge, then sample z just after the capturing edge.
    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] av,
                                 input logic [7:0] bv);
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rop, ra, rb;
    logic [7:0] legalOps [29];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        opcode = 8'h00;
        a      = 8'h00;
        b      = 8'h00;

        // Reset held with random inputs and running clock.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = OP_ADD;
            a      = 8'($urandom_range(1, 255));
            b      = 8'($urandom);
            #3;
            checkOutput("reset_hold", z, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 8'd15, 8'd7);
        checkOutput("add_15_7", z, 8'h16);
        applyStimulus(OP_ADD, 8'hFF, 8'h02);
        checkOutput("add_wrap", z, 8'h01);
        applyStimulus(OP_SUB, 8'd7, 8'd15);
        checkOutput("sub_7_15", z, 8'hF8);

        applyStimulus(OP_ADD, 8'd15, 8'd7);
        checkOutput("b2b_add", z, 8'h16);
        applyStimulus(OP_OR, 8'd15, 8'd7);
        checkOutput("b2b_or", z, 8'h0F);

        applyStimulus(OP_ROL, 8'h01, 8'd7);
        checkOutput("rol_7", z, 8'h80);
        applyStimulus(OP_ROR, 8'h01, 8'd7);
        checkOutput("ror_7", z, 8'h02);
        applyStimulus(OP_ASR, 8'h80, 8'h03);
        checkOutput("asr_3", z, 8'hF0);
        applyStimulus(OP_ASR, 8'h80, 8'hF8);
        checkOutput("asr_amt0", z, 8'h80);
        applyStimulus(OP_ROL, 8'hA5, 8'hF8);
        checkOutput("rol_amt0", z, 8'hA5);
        applyStimulus(OP_SHL, 8'h3C, 8'hF8);
        checkOutput("shl_amt0", z, 8'h3C);

        applyStimulus(OP_LTU, 8'h80, 8'h01);
        checkOutput("ltu", z, 8'h00);
        applyStimulus(OP_LTS, 8'h80, 8'h01);
        checkOutput("lts", z, 8'h01);
        applyStimulus(OP_MAXU, 8'h80, 8'h01);
        checkOutput("maxu", z, 8'h80);
        applyStimulus(OP_EQ, 8'h80, 8'h01);
        checkOutput("eq", z, 8'h00);

        applyStimulus(8'h00, 8'h5A, 8'hC3);
        checkOutput("illegal_00", z, 8'h00);
        applyStimulus(8'h70, 8'h5A, 8'hC3);
        checkOutput("illegal_70", z, 8'h00);
        applyStimulus(8'hFF, 8'h5A, 8'hC3);
        checkOutput("illegal_FF", z, 8'h00);

        // Asynchronous reset mid-cycle while z is nonzero.
        applyStimulus(OP_ADD, 8'd15, 8'd7);
        checkOutput("pre_async", z, 8'h16);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", z, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every opcode with random operands.
        for (int op = 0; op < 256; op++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(8'(op), ra, rb);
            checkOutput($sformatf("sweep_%02h", op), z, refModel(8'(op), ra, rb));
        end

        // Random legal operations.
        for (int i = 0; i < 8; i++) legalOps[i] = 8'(8'h60 + i);
        for (int i = 0; i < 8; i++) legalOps[8 + i] = 8'(8'h78 + i);
        for (int i = 0; i < 8; i++) legalOps[16 + i] = 8'(8'h88 + i);
        for (int i = 0; i < 5; i++) legalOps[24 + i] = 8'(8'h90 + i);
        for (int i = 0; i < 400; i++) begin
            rop = legalOps[$urandom_range(0, 28)];
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            applyStimulus(rop, ra, rb);
            checkOutput($sformatf("rand_%02h_%02h_%02h", rop, ra, rb), z, refModel(rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
